// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial write buffer arbiter: state encoding,
// grant encodings and the buf_count width helper.
package serial_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_START     = 3'd1;
    localparam state_t ST_WAIT_LOW  = 3'd2;
    localparam state_t ST_WAIT_HIGH = 3'd3;
    localparam state_t ST_DONE      = 3'd4;
    localparam state_t ST_GAP       = 3'd5;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_0    = 2'b01;
    localparam logic [1:0] GNT_1    = 2'b10;

    // Bits needed to hold any count from 0 up to and including buf_size.
    function automatic int unsigned count_w(input int unsigned buf_size);
        return $clog2(buf_size + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter: round-robin on ties, or req0-first when the
// fixed_prio strap is set.
module rr_arbiter2
    import serial_tx_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    input  logic       fixed_prio,
    output logic [1:0] grant_c
);

    // last_served=1 means req1 won the previous grant, so req0 is next in line.
    always_comb begin
        grant_c = GNT_NONE;
        case (req)
            2'b01:   grant_c = GNT_0;
            2'b10:   grant_c = GNT_1;
            2'b11:   grant_c = (fixed_prio || last_served) ? GNT_0 : GNT_1;
            default: grant_c = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Arbitrates two requesters onto one serial write buffer and sequences each transfer.
// Define SERIAL_TX_ARB_FIXED_PRIO_EN for fixed req0 priority instead of round-robin.
module serial_tx_arbiter
    import serial_tx_pkg::*;
#(
    parameter  int unsigned BUF_SIZE   = 8,
    parameter  int unsigned GAP_CYCLES = 2,
    localparam int unsigned COUNT_W    = count_w(BUF_SIZE)
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                req0,
    input  logic                req1,
    input  logic [BUF_SIZE-1:0] data0,
    input  logic [BUF_SIZE-1:0] data1,
    input  logic [COUNT_W-1:0]  count0,
    input  logic [COUNT_W-1:0]  count1,
    input  logic                abort,
    output logic [1:0]          grant,
    output logic                ack0,
    output logic                ack1,
    output logic                err,
    output logic                busy,
    output logic                buf_start,
    output logic [BUF_SIZE-1:0] buf_data,
    output logic [COUNT_W-1:0]  buf_count,
    output logic                buf_abort,
    input  logic                buf_done
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

`ifdef SERIAL_TX_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic                last_q, last_d;
    logic [BUF_SIZE-1:0] buf_data_q, buf_data_d;
    logic [COUNT_W-1:0]  buf_count_q, buf_count_d;
    logic                buf_start_q, buf_start_d;
    logic                buf_abort_q, buf_abort_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [1:0]          arb_grant_c;
    logic [COUNT_W-1:0]  cnt_sel_c;

    rr_arbiter2 u_arb (
        .req         ({req1, req0}),
        .last_served (last_q),
        .fixed_prio  (FIXED_PRIO),
        .grant_c     (arb_grant_c)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        buf_data_d  = buf_data_q;
        buf_count_d = buf_count_q;
        gap_cnt_d   = gap_cnt_q;
        buf_start_d = 1'b0;
        buf_abort_d = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err_d       = 1'b0;
        cnt_sel_c   = arb_grant_c[1] ? count1 : count0;

        case (state_q)
            ST_IDLE: begin
                if (arb_grant_c != GNT_NONE) begin
                    grant_d     = arb_grant_c;
                    last_d      = arb_grant_c[1];
                    buf_data_d  = arb_grant_c[1] ? data1 : data0;
                    buf_count_d = (cnt_sel_c > COUNT_W'(BUF_SIZE)) ? COUNT_W'(BUF_SIZE) : cnt_sel_c;
                    state_d     = (cnt_sel_c == '0) ? ST_DONE : ST_START;
                end
            end
            ST_START: begin
                if (abort) begin
                    buf_abort_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    buf_start_d = 1'b1;
                    state_d     = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (abort) begin
                    buf_abort_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (!buf_done) begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (abort) begin
                    buf_abort_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (buf_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // DONE lasts one cycle, so buf_abort_q is high here only for an aborted transfer.
                ack0_d    = grant_q[0];
                ack1_d    = grant_q[1];
                err_d     = buf_abort_q;
                grant_d   = GNT_NONE;
                gap_cnt_d = '0;
                state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= GNT_NONE;
            last_q      <= 1'b1;
            buf_data_q  <= '0;
            buf_count_q <= '0;
            buf_start_q <= 1'b0;
            buf_abort_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            buf_data_q  <= buf_data_d;
            buf_count_q <= buf_count_d;
            buf_start_q <= buf_start_d;
            buf_abort_q <= buf_abort_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign buf_start = buf_start_q;
    assign buf_abort = buf_abort_q;
    assign buf_data  = buf_data_q;
    assign buf_count = buf_count_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter (BUF_SIZE=8, GAP_CYCLES=2); the buffer's
// done level is driven by hand from the transaction task.
module tb_serial_tx_arbiter;

    localparam int unsigned BUF_SIZE = 8;
    localparam int unsigned COUNT_W  = 4;
    localparam int          NV       = 9;

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [3:0] c0;
        logic [7:0] d1;
        logic [3:0] c1;
        logic       abort;
        logic [1:0] exp_grant;
        logic [7:0] exp_data;
        logic [3:0] exp_count;
        logic       exp_start;
        logic       exp_err;
    } vec_t;

    logic               sys_clk = 1'b0;
    logic               rst;
    logic               req0, req1;
    logic [7:0]         data0, data1;
    logic [3:0]         count0, count1;
    logic               abort;
    logic [1:0]         grant;
    logic               ack0, ack1, err, busy, buf_start, buf_abort, buf_done;
    logic [7:0]         buf_data;
    logic [3:0]         buf_count;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[NV];

    always #5 sys_clk = ~sys_clk;

    serial_tx_arbiter #(.BUF_SIZE(BUF_SIZE), .GAP_CYCLES(2)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .count0    (count0),
        .count1    (count1),
        .abort     (abort),
        .grant     (grant),
        .ack0      (ack0),
        .ack1      (ack1),
        .err       (err),
        .busy      (busy),
        .buf_start (buf_start),
        .buf_data  (buf_data),
        .buf_count (buf_count),
        .buf_abort (buf_abort),
        .buf_done  (buf_done)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // One full transfer: arbitration, optional start/abort, ack, gap, back to idle.
    task automatic run_vec(input vec_t v);
        req0 = v.req[0]; req1 = v.req[1];
        data0 = v.d0; data1 = v.d1; count0 = v.c0; count1 = v.c1;
        tick();
        chk("grant", 32'(grant), 32'(v.exp_grant));
        chk("buf_data", 32'(buf_data), 32'(v.exp_data));
        chk("buf_count", 32'(buf_count), 32'(v.exp_count));
        chk("busy_active", 32'(busy), 32'd1);
        chk("start_not_early", 32'(buf_start), 32'd0);
        // loser withdraws; requester inputs change after grant
        req0 = v.exp_grant[0]; req1 = v.exp_grant[1];
        data0 = ~v.d0; data1 = ~v.d1; count0 = 4'd1; count1 = 4'd1;
        if (v.exp_start) begin
            tick();
            chk("buf_start", 32'(buf_start), 32'd1);
            buf_done = 1'b0;
            tick();
            chk("buf_start_pulse", 32'(buf_start), 32'd0);
            if (v.abort) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("buf_abort", 32'(buf_abort), 32'd1);
                buf_done = 1'b1;
                tick();
                chk("buf_abort_pulse", 32'(buf_abort), 32'd0);
            end else begin
                tick();
                tick();
                chk("buf_data_hold", 32'(buf_data), 32'(v.exp_data));
                chk("no_ack_while_writing", 32'({ack1, ack0}), 32'd0);
                buf_done = 1'b1;
                tick();
                chk("ack_not_early", 32'({ack1, ack0}), 32'd0);
                tick();
            end
        end else begin
            tick();
            chk("no_start_zero_count", 32'(buf_start), 32'd0);
        end
        chk("ack", 32'({ack1, ack0}), 32'(v.exp_grant));
        chk("err", 32'(err), 32'(v.exp_err));
        chk("grant_cleared", 32'(grant), 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("ack_pulse", 32'({ack1, ack0}), 32'd0);
        chk("err_pulse", 32'(err), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        tick();
        chk("idle_after_gap", 32'(busy), 32'd0);
    endtask

    initial begin
        //           req    d0     c0    d1     c1    abt   grant  data   cnt   start err
        vecs[0] = '{2'b11, 8'hA5, 4'd3, 8'h5A, 4'd4, 1'b0, 2'b01, 8'hA5, 4'd3, 1'b1, 1'b0};
`ifdef SERIAL_TX_ARB_FIXED_PRIO_EN
        vecs[1] = '{2'b11, 8'h11, 4'd2, 8'hE7, 4'd5, 1'b0, 2'b01, 8'h11, 4'd2, 1'b1, 1'b0};
`else
        vecs[1] = '{2'b11, 8'h11, 4'd2, 8'hE7, 4'd5, 1'b0, 2'b10, 8'hE7, 4'd5, 1'b1, 1'b0};
`endif
        vecs[2] = '{2'b01, 8'h9C, 4'd8, 8'h00, 4'd0, 1'b0, 2'b01, 8'h9C, 4'd8, 1'b1, 1'b0};
        vecs[3] = '{2'b10, 8'h00, 4'd5, 8'h3C, 4'd0, 1'b0, 2'b10, 8'h3C, 4'd0, 1'b0, 1'b0};
        vecs[4] = '{2'b01, 8'hF0, 4'd6, 8'h00, 4'd0, 1'b1, 2'b01, 8'hF0, 4'd6, 1'b1, 1'b1};
        vecs[5] = '{2'b01, 8'h81, 4'd12, 8'h00, 4'd0, 1'b0, 2'b01, 8'h81, 4'd8, 1'b1, 1'b0};
        vecs[6] = '{2'b10, 8'h00, 4'd0, 8'h42, 4'd15, 1'b0, 2'b10, 8'h42, 4'd8, 1'b1, 1'b0};
        vecs[7] = '{2'b11, 8'h0F, 4'd1, 8'hF1, 4'd2, 1'b0, 2'b01, 8'h0F, 4'd1, 1'b1, 1'b0};
`ifdef SERIAL_TX_ARB_FIXED_PRIO_EN
        vecs[8] = '{2'b11, 8'h2D, 4'd7, 8'hD2, 4'd3, 1'b0, 2'b01, 8'h2D, 4'd7, 1'b1, 1'b0};
`else
        vecs[8] = '{2'b11, 8'h2D, 4'd7, 8'hD2, 4'd3, 1'b0, 2'b10, 8'hD2, 4'd3, 1'b1, 1'b0};
`endif

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; abort = 1'b0; buf_done = 1'b1;
        data0 = 8'hFF; data1 = 8'hFF; count0 = 4'd3; count1 = 4'd3;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_acks_err", 32'({ack1, ack0, err}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_buf_ctl", 32'({buf_start, buf_abort}), 32'd0);
        chk("rst_buf_data", 32'(buf_data), 32'd0);
        chk("rst_buf_count", 32'(buf_count), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end

        // abort while idle has no effect
        abort = 1'b1;
        tick();
        chk("idle_abort_buf_abort", 32'(buf_abort), 32'd0);
        chk("idle_abort_busy", 32'(busy), 32'd0);
        tick();
        chk("idle_abort_no_ack", 32'({ack1, ack0, err}), 32'd0);
        abort = 1'b0;
        tick();

        // reset in WAIT_LOW: outputs clear at once, no ack, round-robin pointer restored
        req0 = 1'b1; data0 = 8'h77; count0 = 4'd5;
        tick();
        tick();
        chk("pre_rst_start", 32'(buf_start), 32'd1);
        buf_done = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_flags", 32'({ack1, ack0, err, busy, buf_start, buf_abort}), 32'd0);
        chk("mid_rst_buf_data", 32'(buf_data), 32'd0);
        chk("mid_rst_buf_count", 32'(buf_count), 32'd0);
        req0 = 1'b0; buf_done = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_quiet", 32'({ack1, ack0, err, busy, buf_abort}), 32'd0);
        end
        run_vec('{2'b11, 8'h66, 4'd4, 8'h99, 4'd4, 1'b0, 2'b01, 8'h66, 4'd4, 1'b1, 1'b0});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
